// File: rtl/fir_sram_tap_ctrl.sv
// Sample-SRAM controller for the serial FIR: writes each accepted sample into a circular delay line, then streams taps newest-to-oldest.
// Latency: the write issues 1 cycle after accept, read k issues 2+k cycles after accept, tap k is valid 3+k cycles after accept; one sample per TAPS+3 cycles.
// Backpressure: din_ready is high only in IDLE; the tap stream is never stalled. Option FIR_TAP_INIT_CLEAR_EN clears the SRAM after reset instead of masking unfilled taps.
module fir_sram_tap_ctrl #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 6,
  parameter int TAPS   = 16,
  localparam int IWIDTH = $clog2(TAPS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic [DWIDTH-1:0] din_data,
  output logic [AWIDTH-1:0] sram_address,
  output logic              sram_write_req,
  output logic [DWIDTH-1:0] sram_write_data,
  input  logic [DWIDTH-1:0] sram_read_data,
  output logic              tap_valid,
  output logic [DWIDTH-1:0] tap_data,
  output logic [IWIDTH-1:0] tap_index,
  output logic              tap_last
);

  localparam logic [AWIDTH-1:0] ADDR_LAST = AWIDTH'(TAPS - 1);
  localparam logic [IWIDTH-1:0] K_LAST    = IWIDTH'(TAPS - 1);

  typedef enum logic [2:0] {INIT, IDLE, WRITE, READ, DRAIN} state_t;

  state_t state, next_state;

  logic [AWIDTH-1:0] wr_ptr;
  logic [IWIDTH-1:0] rd_k;
  logic              accept;

  logic              din_ready_nxt;
  logic [AWIDTH-1:0] sram_address_nxt;
  logic              sram_write_req_nxt;
  logic [DWIDTH-1:0] sram_write_data_nxt;
  logic              tap_valid_nxt;
  logic [IWIDTH-1:0] tap_index_nxt;
  logic              tap_last_nxt;

`ifdef FIR_TAP_INIT_CLEAR_EN
  localparam state_t RESET_STATE = INIT;
  logic [IWIDTH-1:0] init_cnt;
`else
  localparam state_t RESET_STATE = IDLE;
  // fill saturates at TAPS, so it needs one bit more than a tap index
  logic [IWIDTH:0]   fill;
  logic              tap_mask;
`endif

  assign accept = din_valid && din_ready && (state == IDLE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RESET_STATE;
    else        state <= next_state;
  end

  // Next-state decode
  always_comb begin
    next_state = state;
    case (state)
`ifdef FIR_TAP_INIT_CLEAR_EN
      INIT:  if (init_cnt == K_LAST) next_state = IDLE;
`else
      INIT:  next_state = IDLE;
`endif
      IDLE:  if (accept) next_state = WRITE;
      WRITE: next_state = READ;
      READ:  if (rd_k == K_LAST) next_state = DRAIN;
      DRAIN: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output decode: values the output registers take at the next edge
  always_comb begin
    din_ready_nxt       = 1'b0;
    sram_address_nxt    = sram_address;
    sram_write_req_nxt  = 1'b0;
    sram_write_data_nxt = sram_write_data;
    tap_valid_nxt       = (state == READ);
    tap_index_nxt       = (state == READ) ? rd_k : '0;
    tap_last_nxt        = (state == READ) && (rd_k == K_LAST);
    case (state)
`ifdef FIR_TAP_INIT_CLEAR_EN
      INIT: begin
        sram_write_req_nxt  = 1'b1;
        sram_address_nxt    = AWIDTH'(init_cnt);
        sram_write_data_nxt = '0;
      end
`endif
      IDLE: begin
        if (accept) begin
          sram_write_req_nxt  = 1'b1;
          sram_address_nxt    = wr_ptr;
          sram_write_data_nxt = din_data;
        end else begin
          din_ready_nxt = 1'b1;
        end
      end
      // first read (k=0) hits the location just written
      WRITE: sram_address_nxt = wr_ptr;
      READ: begin
        if (rd_k != K_LAST)
          sram_address_nxt = (sram_address == '0) ? ADDR_LAST : sram_address - AWIDTH'(1);
      end
      DRAIN: din_ready_nxt = 1'b1;
      default: ;
    endcase
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_ready       <= 1'b0;
      sram_address    <= '0;
      sram_write_req  <= 1'b0;
      sram_write_data <= '0;
      tap_valid       <= 1'b0;
      tap_index       <= '0;
      tap_last        <= 1'b0;
    end else begin
      din_ready       <= din_ready_nxt;
      sram_address    <= sram_address_nxt;
      sram_write_req  <= sram_write_req_nxt;
      sram_write_data <= sram_write_data_nxt;
      tap_valid       <= tap_valid_nxt;
      tap_index       <= tap_index_nxt;
      tap_last        <= tap_last_nxt;
    end
  end

  // Write pointer and read-tap counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_k   <= '0;
    end else begin
      if (state == WRITE)
        rd_k <= '0;
      else if (state == READ && rd_k != K_LAST)
        rd_k <= rd_k + IWIDTH'(1);
      if (state == DRAIN)
        wr_ptr <= (wr_ptr == ADDR_LAST) ? '0 : wr_ptr + AWIDTH'(1);
    end
  end

`ifdef FIR_TAP_INIT_CLEAR_EN
  // Clear-sweep address counter, only active in INIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              init_cnt <= '0;
    else if (state == INIT)  init_cnt <= init_cnt + IWIDTH'(1);
  end

  assign tap_data = sram_read_data;
`else
  // Fill count and per-tap mask; the mask is registered so it lines up with tap_valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill     <= '0;
      tap_mask <= 1'b0;
    end else begin
      if (accept && fill != (IWIDTH+1)'(TAPS))
        fill <= fill + (IWIDTH+1)'(1);
      tap_mask <= (state == READ) && ({1'b0, rd_k} >= fill);
    end
  end

  // taps older than the number of samples seen read stale SRAM, so present 0
  assign tap_data = tap_mask ? '0 : sram_read_data;
`endif

endmodule

// File: tb/tb_fir_sram_tap_ctrl.sv
// Directed bench for fir_sram_tap_ctrl with TAPS=4 and a behavioural single-port SRAM.
module tb_fir_sram_tap_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       din_valid;
  logic       din_ready;
  logic [7:0] din_data;
  logic [5:0] sram_address;
  logic       sram_write_req;
  logic [7:0] sram_write_data;
  logic [7:0] sram_read_data;
  logic       tap_valid;
  logic [7:0] tap_data;
  logic [1:0] tap_index;
  logic       tap_last;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem [0:63];
  logic       mem_init = 1'b1;

  fir_sram_tap_ctrl #(.DWIDTH(8), .AWIDTH(6), .TAPS(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .din_valid(din_valid), .din_ready(din_ready), .din_data(din_data),
    .sram_address(sram_address), .sram_write_req(sram_write_req),
    .sram_write_data(sram_write_data), .sram_read_data(sram_read_data),
    .tap_valid(tap_valid), .tap_data(tap_data), .tap_index(tap_index), .tap_last(tap_last)
  );

  always #5 clk = ~clk;

  // single-port SRAM, one-cycle read latency, preloaded with 0xFF
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 8'hFF;
    end else if (sram_write_req) begin
      mem[sram_address] <= sram_write_data;
    end
    sram_read_data <= mem[sram_address];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_din_ready"}, 32'(din_ready), 0);
    chk({tag, "_addr"},      32'(sram_address), 0);
    chk({tag, "_wreq"},      32'(sram_write_req), 0);
    chk({tag, "_wdata"},     32'(sram_write_data), 0);
    chk({tag, "_tap_valid"}, 32'(tap_valid), 0);
    chk({tag, "_tap_index"}, 32'(tap_index), 0);
    chk({tag, "_tap_last"},  32'(tap_last), 0);
  endtask

  // called with rst_n just released, between clock edges
  task automatic after_reset();
`ifdef FIR_TAP_INIT_CLEAR_EN
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("init_wreq",  32'(sram_write_req), 1);
      chk("init_addr",  32'(sram_address), i);
      chk("init_wdata", 32'(sram_write_data), 0);
      chk("init_ready", 32'(din_ready), 0);
    end
`endif
    cyc();
    chk("idle_ready", 32'(din_ready), 1);
    chk("idle_wreq",  32'(sram_write_req), 0);
    chk("idle_tapv",  32'(tap_valid), 0);
  endtask

  // one full sample: accept, write, 4 reads, drain; e holds expected taps {k3,k2,k1,k0}
  task automatic do_sample(input logic [7:0] d, input int wa, input logic [31:0] e);
    chk("pre_ready", 32'(din_ready), 1);
    din_valid = 1'b1;
    din_data  = d;
    cyc();
    din_valid = 1'b0;
    chk("wr_req",   32'(sram_write_req), 1);
    chk("wr_addr",  32'(sram_address), wa);
    chk("wr_data",  32'(sram_write_data), 32'(d));
    chk("wr_ready", 32'(din_ready), 0);
    chk("wr_tapv",  32'(tap_valid), 0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("rd_addr",  32'(sram_address), (wa - k + 4) % 4);
      chk("rd_req",   32'(sram_write_req), 0);
      chk("rd_ready", 32'(din_ready), 0);
      chk("rd_tapv",  32'(tap_valid), (k > 0) ? 1 : 0);
      if (k > 0) begin
        chk("tap_index", 32'(tap_index), k - 1);
        chk("tap_data",  32'(tap_data), 32'(e[8*(k-1) +: 8]));
        chk("tap_last",  32'(tap_last), 0);
      end
    end
    cyc();
    chk("drain_tapv",  32'(tap_valid), 1);
    chk("drain_index", 32'(tap_index), 3);
    chk("drain_last",  32'(tap_last), 1);
    chk("drain_data",  32'(tap_data), 32'(e[31:24]));
    chk("drain_ready", 32'(din_ready), 0);
    cyc();
    chk("post_ready", 32'(din_ready), 1);
    chk("post_tapv",  32'(tap_valid), 0);
    chk("post_last",  32'(tap_last), 0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int last_c;
    int lasts;
    logic acc_now;

    rst_n     = 1'b1;
    din_valid = 1'b0;
    din_data  = 8'h00;
    #3 rst_n = 1'b0;
    #1 chk_reset_vals("rst0");
    cyc();
    mem_init = 1'b0;
    cyc();
    cyc();
    chk_reset_vals("rst_hold");
    rst_n = 1'b1;
    after_reset();

    // single sample into an empty delay line, then wrap-around overwrite
    do_sample(8'h11, 0, 32'h00000011);
    do_sample(8'h22, 1, 32'h00001122);
    do_sample(8'h33, 2, 32'h00112233);
    do_sample(8'h44, 3, 32'h11223344);
    do_sample(8'h55, 0, 32'h22334455);

    // din_valid held high for 8 samples
    acc    = 0;
    last_c = 0;
    lasts  = 0;
    din_valid = 1'b1;
    din_data  = 8'h60;
    for (int c = 0; c < 70; c++) begin
      if (tap_last) lasts++;
      acc_now = din_valid && din_ready;
      if (acc_now) begin
        acc++;
        if (acc > 1) chk("accept_spacing", 32'(c - last_c), 7);
        last_c = c;
      end
      cyc();
      if (acc_now) begin
        chk("stream_wdata", 32'(sram_write_data), 32'(din_data));
        din_data = din_data + 8'h01;
        if (acc == 8) din_valid = 1'b0;
      end
    end
    chk("stream_accepts", 32'(acc), 8);
    chk("stream_lasts",   32'(lasts), 8);

    // reset in the middle of a read burst (wr_ptr is 1 here)
    chk("mid_pre_ready", 32'(din_ready), 1);
    din_valid = 1'b1;
    din_data  = 8'h77;
    cyc();
    din_valid = 1'b0;
    chk("mid_wr_addr", 32'(sram_address), 1);
    cyc();
    chk("mid_rd0_addr", 32'(sram_address), 1);
    cyc();
    chk("mid_rd1_addr", 32'(sram_address), 0);
    chk("mid_tap0",     32'(tap_data), 'h77);
    cyc();
    chk("mid_rd2_addr", 32'(sram_address), 3);
    chk("mid_tap1_vld", 32'(tap_valid), 1);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("rst_async");
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rst_no_tap", 32'(tap_valid), 0);
    end
    rst_n = 1'b1;
    after_reset();

    // fresh fill after reset: stale SRAM contents must not leak into the taps
    do_sample(8'hA0, 0, 32'h000000A0);
    do_sample(8'hB0, 1, 32'h0000A0B0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
